router_sync_ctrl: RTL and testbench

//  Write-side steering and read-side watchdog between the router FSM and the three output FIFOs.
//  - Latches the destination address in the header cycle.
//  - Steers the FSM write enable to one FIFO and returns that FIFO's full flag.
//  - Drives per-port valid from the FIFO empty flags.
//  - Issues a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT cycles.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_timeout_cnt.sv | 43 ++++
 rtl/router_sync_ctrl.sv | 112 +++++++++++
 tb/tb_router_sync_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared address encodings and helpers for the router write-side controller.
package router_pkg;
    localparam logic [1:0] ADDR_P0   = 2'b00;
    localparam logic [1:0] ADDR_P1   = 2'b01;
    localparam logic [1:0] ADDR_P2   = 2'b10;
    localparam logic [1:0] ADDR_NONE = 2'b11;
    localparam int         NUM_PORTS = 3;

    // ADDR_NONE maps to no enable, so unroutable packets are dropped.
    function automatic logic [2:0] onehot3(input logic [1:0] addr);
        logic [2:0] oh;
        case (addr)
            ADDR_P0: oh = 3'b001;
            ADDR_P1: oh = 3'b010;
            ADDR_P2: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction
endpackage

// File: rtl/router_timeout_cnt.sv
// Per-port watchdog: fires a one-cycle soft reset after TIMEOUT consecutive
// cycles of data sitting unread.
module router_timeout_cnt #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_reset_q, soft_reset_d;

    // The pulse cycle itself does not count, so a still-full FIFO restarts
    // its count the cycle after the pulse.
    always_comb begin
        cnt_d        = '0;
        soft_reset_d = 1'b0;
        if (!soft_reset_q && vld && !rd) begin
            if (cnt_q == CNT_MAX) begin
                soft_reset_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;
endmodule

// File: rtl/router_sync_ctrl.sv
// Router write steering, full mux, port valids and read watchdogs.
// Optional ROUTER_TIMEOUT_STATUS_EN adds sticky per-port timeout flags.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ROUTER_TIMEOUT_STATUS_EN
    input  logic       timeout_clr,
    output logic [2:0] timeout_sticky,
`endif
    input  logic       detect_add,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic       write_enb_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);
    logic [1:0] addr_q, addr_d;
    logic [NUM_PORTS-1:0] vld_vec, rd_vec, soft_vec;

    always_comb begin
        addr_d = addr_q;
        if (detect_add && pkt_valid) begin
            addr_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= ADDR_NONE;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Steering uses the registered address, so a header's own cycle still
    // writes to the previous destination.
    assign write_enb = write_enb_reg ? onehot3(addr_q) : 3'b000;

    always_comb begin
        fifo_full = 1'b0;
        case (addr_q)
            ADDR_P0: fifo_full = full_0;
            ADDR_P1: fifo_full = full_1;
            ADDR_P2: fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld_vec = {~empty_2, ~empty_1, ~empty_0};
    assign rd_vec  = {read_enb_2, read_enb_1, read_enb_0};

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wdog
            router_timeout_cnt #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .vld        (vld_vec[gi]),
                .rd         (rd_vec[gi]),
                .soft_reset (soft_vec[gi])
            );
        end
    endgenerate

    assign vld_out_0    = vld_vec[0];
    assign vld_out_1    = vld_vec[1];
    assign vld_out_2    = vld_vec[2];
    assign soft_reset_0 = soft_vec[0];
    assign soft_reset_1 = soft_vec[1];
    assign soft_reset_2 = soft_vec[2];

`ifdef ROUTER_TIMEOUT_STATUS_EN
    logic [2:0] sticky_q, sticky_d;

    // A live pulse always wins over a clear, and is visible in the same cycle.
    always_comb begin
        sticky_d = soft_vec | (sticky_q & ~{3{timeout_clr}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign timeout_sticky = sticky_q | soft_vec;
`endif
endmodule

// File: tb/tb_router_sync_ctrl.sv
// Self-checking bench for router_sync_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the routing/watchdog rules.
module tb_router_sync_ctrl;
    localparam int TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       detect_add = 1'b0, pkt_valid = 1'b0, write_enb_reg = 1'b0;
    logic [1:0] din = 2'b00;
    logic [2:0] full = 3'b000, empty = 3'b111, rd = 3'b000;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       timeout_clr = 1'b0;
    logic [2:0] timeout_sticky;

    int total = 0;
    int bad   = 0;

    // Model state: destination, consecutive unread cycles, pending pulses.
    logic [1:0] m_addr = 2'b11;
    int         m_run [3];
    logic [2:0] m_pulse = 3'b000;
    logic [2:0] m_sticky = 3'b000;

    always #5 clk = ~clk;

    router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ROUTER_TIMEOUT_STATUS_EN
        .timeout_clr   (timeout_clr),
        .timeout_sticky(timeout_sticky),
`endif
        .detect_add    (detect_add),
        .pkt_valid     (pkt_valid),
        .din           (din),
        .write_enb_reg (write_enb_reg),
        .full_0        (full[0]),
        .full_1        (full[1]),
        .full_2        (full[2]),
        .empty_0       (empty[0]),
        .empty_1       (empty[1]),
        .empty_2       (empty[2]),
        .read_enb_0    (rd[0]),
        .read_enb_1    (rd[1]),
        .read_enb_2    (rd[2]),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    wire [2:0] sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
    wire [2:0] vld = {vld_out_2, vld_out_1, vld_out_0};

    function automatic logic [2:0] exp_we();
        if (!write_enb_reg || m_addr == 2'b11) return 3'b000;
        return 3'(1 << m_addr);
    endfunction

    function automatic logic exp_full();
        if (m_addr == 2'b11) return 1'b0;
        return full[m_addr];
    endfunction

    task automatic model_reset();
        m_addr = 2'b11;
        m_pulse = 3'b000;
        m_sticky = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    // Advance one clock edge; the model consumes this cycle's inputs.
    task automatic tick();
        logic [2:0] np;
        int         nr [3];
        logic [1:0] na;
        logic [2:0] ns;
        for (int i = 0; i < 3; i++) begin
            np[i] = 1'b0;
            nr[i] = 0;
            if (!m_pulse[i] && !empty[i] && !rd[i]) begin
                if (m_run[i] + 1 == TIMEOUT) np[i] = 1'b1;
                else nr[i] = m_run[i] + 1;
            end
        end
        na = (detect_add && pkt_valid) ? din : m_addr;
        ns = (m_sticky & ~({3{timeout_clr}} & ~m_pulse)) | np;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_addr = na;
            m_pulse = np;
            m_sticky = ns;
            for (int i = 0; i < 3; i++) m_run[i] = nr[i];
        end
        #1;
    endtask

    task automatic flush();
        empty = 3'b111; rd = 3'b000;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; write_enb_reg = 1'b1; full = 3'b111; empty = 3'b010;
        model_reset();
        tick();
        total++;
        if (write_enb !== 3'b000) begin bad++; $display("FAIL reset_we got=%b want=000", write_enb); end
        total++;
        if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", fifo_full); end
        total++;
        if (sr !== 3'b000) begin bad++; $display("FAIL reset_sr got=%b want=000", sr); end
        total++;
        if (vld !== 3'b101) begin bad++; $display("FAIL reset_vld got=%b want=101", vld); end
        rst = 1'b0; write_enb_reg = 1'b0; full = 3'b000; empty = 3'b111;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_addr_latch();
        detect_add = 1'b1; pkt_valid = 1'b1; din = 2'b01; write_enb_reg = 1'b1;
        #1;
        total++;
        if (write_enb !== 3'b000) begin bad++; $display("FAIL hdr_same_cycle got=%b want=000", write_enb); end
        tick();
        detect_add = 1'b0; pkt_valid = 1'b0; din = 2'b10;
        for (int f = 0; f < 8; f++) begin
            full = 3'(f);
            #1;
            total++;
            if (write_enb !== 3'b010) begin bad++; $display("FAIL steer_p1 got=%b want=010", write_enb); end
            total++;
            if (fifo_full !== full[1]) begin bad++; $display("FAIL full_p1 got=%b want=%b", fifo_full, full[1]); end
        end
        write_enb_reg = 1'b0;
        #1;
        total++;
        if (write_enb !== 3'b000) begin bad++; $display("FAIL steer_idle got=%b want=000", write_enb); end
        full = 3'b000;
        $display("test_addr_latch done");
    endtask

    task automatic test_timeout_single();
        int n;
        flush();
        empty = 3'b011;
        n = 0;
        do begin tick(); n++; end while (!soft_reset_2 && n < 100);
        total++;
        if (n != TIMEOUT) begin bad++; $display("FAIL first_pulse cycles=%0d want=%0d", n, TIMEOUT); end
        total++;
        if (vld_out_2 !== 1'b1) begin bad++; $display("FAIL vld2 got=%b want=1", vld_out_2); end
        tick();
        total++;
        if (soft_reset_2 !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b want=0", soft_reset_2); end
        n = 0;
        do begin tick(); n++; end while (!soft_reset_2 && n < 100);
        total++;
        if (n != TIMEOUT) begin bad++; $display("FAIL second_pulse cycles=%0d want=%0d", n, TIMEOUT); end
        $display("test_timeout_single done");
    endtask

    task automatic test_read_cancel();
        int n;
        logic seen;
        flush();
        empty = 3'b110;
        seen = 1'b0;
        for (int c = 1; c <= TIMEOUT - 1; c++) begin
            rd[0] = (c == TIMEOUT - 1);
            tick();
            if (soft_reset_0) seen = 1'b1;
        end
        rd[0] = 1'b0;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL read_cancel got=1 want=0"); end
        n = 0;
        do begin tick(); n++; end while (!soft_reset_0 && n < 100);
        total++;
        if (n != TIMEOUT) begin bad++; $display("FAIL restart_pulse cycles=%0d want=%0d", n, TIMEOUT); end
        $display("test_read_cancel done");
    endtask

    task automatic test_no_dest();
        flush();
        detect_add = 1'b1; pkt_valid = 1'b1; din = 2'b11;
        tick();
        detect_add = 1'b0; pkt_valid = 1'b0; write_enb_reg = 1'b1;
        for (int f = 0; f < 8; f++) begin
            full = 3'(f);
            #1;
            total++;
            if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
                bad++; $display("FAIL no_dest full=%b we=%b ff=%b want we=000 ff=0", full, write_enb, fifo_full);
            end
        end
        write_enb_reg = 1'b0; full = 3'b000;
        $display("test_no_dest done");
    endtask

    task automatic test_all_ports();
        int n;
        logic seen;
        flush();
        empty = 3'b000;
        n = 0;
        do begin tick(); n++; end while (sr == 3'b000 && n < 100);
        total++;
        if (n != TIMEOUT || sr !== 3'b111) begin
            bad++; $display("FAIL all_ports cycles=%0d sr=%b want %0d/111", n, sr, TIMEOUT);
        end
        flush();
        empty = 3'b000;
        for (int c = 0; c < 15; c++) tick();
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (sr !== 3'b000) begin bad++; $display("FAIL mid_rst_sr got=%b want=000", sr); end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            tick();
            if (sr != 3'b000) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_early got=1 want=0"); end
        tick();
        total++;
        if (sr !== 3'b111) begin bad++; $display("FAIL mid_rst_restart got=%b want=111", sr); end
        flush();
        $display("test_all_ports done");
    endtask

`ifdef ROUTER_TIMEOUT_STATUS_EN
    task automatic test_sticky();
        int n;
        flush();
        timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
        empty = 3'b101;
        n = 0;
        do begin tick(); n++; end while (!soft_reset_1 && n < 100);
        total++;
        if (timeout_sticky !== 3'b010) begin bad++; $display("FAIL sticky_set got=%b want=010", timeout_sticky); end
        empty = 3'b111;
        for (int c = 0; c < 5; c++) tick();
        total++;
        if (timeout_sticky !== 3'b010) begin bad++; $display("FAIL sticky_hold got=%b want=010", timeout_sticky); end
        timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
        total++;
        if (timeout_sticky !== 3'b000) begin bad++; $display("FAIL sticky_clr got=%b want=000", timeout_sticky); end
        empty = 3'b101;
        n = 0;
        do begin tick(); n++; end while (!soft_reset_1 && n < 100);
        timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
        tick();
        total++;
        if (timeout_sticky[1] !== 1'b1) begin bad++; $display("FAIL sticky_set_prio got=%b want=1", timeout_sticky[1]); end
        flush();
        $display("test_sticky done");
    endtask
`endif

    task automatic test_random();
        int pulses = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            detect_add = $urandom_range(0, 3) == 0;
            pkt_valid = $urandom_range(0, 1);
            din = 2'($urandom_range(0, 3));
            write_enb_reg = $urandom_range(0, 1);
            full = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                empty[i] = ($urandom_range(0, 15) == 0);
                rd[i] = ($urandom_range(0, 40) == 0);
            end
            timeout_clr = ($urandom_range(0, 7) == 0);
            if (rst) model_reset();
            #1;
            total++;
            if (write_enb !== exp_we() || fifo_full !== exp_full() || vld !== ~empty) begin
                bad++; $display("FAIL rand_comb cyc=%0d we=%b ff=%b vld=%b want %b %b %b",
                                c, write_enb, fifo_full, vld, exp_we(), exp_full(), ~empty);
            end
            total++;
            if (sr !== m_pulse) begin bad++; $display("FAIL rand_sr cyc=%0d got=%b want=%b", c, sr, m_pulse); end
`ifdef ROUTER_TIMEOUT_STATUS_EN
            total++;
            if (timeout_sticky !== m_sticky) begin
                bad++; $display("FAIL rand_sticky cyc=%0d got=%b want=%b", c, timeout_sticky, m_sticky);
            end
`endif
            if (m_pulse != 3'b000) pulses++;
            tick();
        end
        rst = 1'b0; timeout_clr = 1'b0;
        $display("test_random done pulse_cycles=%0d", pulses);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_addr_latch();
        test_timeout_single();
        test_read_cancel();
        test_no_dest();
        test_all_ports();
`ifdef ROUTER_TIMEOUT_STATUS_EN
        test_sticky();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
